// File: rtl/video_probe_tap.sv
// Camera timing probe tap: frame/line/pixel counters, geometry checks and a one-cycle trigger.
// Optional per-frame pixel XOR checksum is compiled in with VPT_CHECKSUM_EN.
module video_probe_tap #(
    parameter int H_ACT  = 640,
    parameter int V_ACT  = 480,
    parameter int PIX_W  = 12,
    parameter int LINE_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vsync_i,
    input  logic              href_i,
    input  logic [7:0]        pix_i,
    input  logic [7:0]        trig_frame_i,
    input  logic              clr_i,
    output logic [7:0]        frame_cnt_o,
    output logic [LINE_W-1:0] line_cnt_o,
    output logic [PIX_W-1:0]  pix_cnt_o,
    output logic [1:0]        state_o,
    output logic [1:0]        err_o,
    output logic              trig_o,
    output logic [7:0]        csum_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VBLANK = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    localparam logic [PIX_W-1:0]  PIX_MAX  = '1;
    localparam logic [LINE_W-1:0] LINE_MAX = '1;

    state_t            state_q;
    logic              vs_r1, vs_r2, hr_r1, hr_r2;
    logic              vs_rise, hr_rise, hr_fall, live;
    logic [1:0]        err_set, err_next;
    logic [7:0]        frame_next;
    logic              trig_next;
    logic [LINE_W:0]   line_eff;

    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_r1 <= 1'b0;
            vs_r2 <= 1'b0;
            hr_r1 <= 1'b0;
            hr_r2 <= 1'b0;
        end else begin
            vs_r1 <= vsync_i;
            vs_r2 <= vs_r1;
            hr_r1 <= href_i;
            hr_r2 <= hr_r1;
        end
    end

    assign vs_rise = vs_r1 & ~vs_r2;
    assign hr_rise = hr_r1 & ~hr_r2;
    assign hr_fall = ~hr_r1 & hr_r2;
    assign live    = (state_q == VBLANK) || (state_q == ACTIVE);
    assign state_o = state_q;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        err_set  = 2'b00;
        line_eff = {1'b0, line_cnt_o} + (LINE_W + 1)'(hr_fall);
        if (live && hr_fall && (pix_cnt_o != PIX_W'(H_ACT)))
            err_set[0] = 1'b1;
        if (live && vs_rise && (line_eff != (LINE_W + 1)'(V_ACT)))
            err_set[1] = 1'b1;
        // A clear coinciding with a new error still leaves the new error set.
        err_next   = (clr_i ? 2'b00 : err_o) | err_set;
        frame_next = vs_rise ? frame_cnt_o + 8'd1 : frame_cnt_o;
        trig_next  = (vs_rise && (frame_next == trig_frame_i)) || ((err_next & ~err_o) != 2'b00);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            frame_cnt_o <= 8'd0;
            line_cnt_o  <= '0;
            pix_cnt_o   <= '0;
            err_o       <= 2'b00;
            trig_o      <= 1'b0;
        end else begin
            frame_cnt_o <= frame_next;
            err_o       <= err_next;
            trig_o      <= trig_next;
            if (live) begin
                if (hr_fall)
                    pix_cnt_o <= '0;
                else if (hr_r1 && (pix_cnt_o != PIX_MAX))
                    pix_cnt_o <= pix_cnt_o + PIX_W'(1);
                if (vs_rise)
                    line_cnt_o <= '0;
                else if (hr_fall && (line_cnt_o != LINE_MAX))
                    line_cnt_o <= line_cnt_o + LINE_W'(1);
            end
            case (state_q)
                VBLANK: begin
                    if (vs_rise)
                        state_q <= VBLANK;
                    else if (hr_rise)
                        state_q <= ACTIVE;
                end
                ACTIVE: begin
                    if (vs_rise || hr_fall)
                        state_q <= VBLANK;
                end
                default: state_q <= vs_rise ? VBLANK : IDLE;
            endcase
        end
    end

`ifdef VPT_CHECKSUM_EN
    logic [7:0] pix_r1, acc, acc_next;

    always_comb acc_next = acc ^ (hr_r1 ? pix_r1 : 8'h00);

    // The latched checksum includes the pixel arriving in the frame-start cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_r1 <= 8'h00;
            acc    <= 8'h00;
            csum_o <= 8'h00;
        end else begin
            pix_r1 <= pix_i;
            if (vs_rise && live) begin
                csum_o <= acc_next;
                acc    <= 8'h00;
            end else begin
                acc <= acc_next;
            end
        end
    end
`else
    logic unused_pix;
    assign unused_pix = ^pix_i;
    assign csum_o     = 8'h00;
`endif

endmodule

// File: tb/tb_video_probe_tap.sv
// Self-checking bench for video_probe_tap (H_ACT=4, V_ACT=3) against an event-level reference model.
module tb_video_probe_tap;

    localparam int H = 4;
    localparam int V = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vsync, href, clr;
    logic [7:0]  pix, trig_frame;
    logic [7:0]  frame_cnt;
    logic [11:0] line_cnt, pix_cnt;
    logic [1:0]  state, err;
    logic        trig;
    logic [7:0]  csum;

    int checks = 0;
    int errors = 0;
    int trig_cnt = 0;

    // Reference model: pin history plus frame-level bookkeeping.
    bit         p1_vs, p2_vs, p1_hr, p2_hr;
    logic [7:0] p1_px;
    int         m_state, m_frame, m_line, m_pix;
    logic [1:0] m_err;
    bit         m_trig;
    logic [7:0] m_csum;
    logic [7:0] frame_px[$];

    video_probe_tap #(.H_ACT(H), .V_ACT(V), .PIX_W(12), .LINE_W(12)) dut (
        .clk(clk), .rst_n(rst_n), .vsync_i(vsync), .href_i(href), .pix_i(pix),
        .trig_frame_i(trig_frame), .clr_i(clr), .frame_cnt_o(frame_cnt),
        .line_cnt_o(line_cnt), .pix_cnt_o(pix_cnt), .state_o(state),
        .err_o(err), .trig_o(trig), .csum_o(csum)
    );

    always #5 clk = ~clk;

    initial begin
        #500us;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit vr, hrr, hf, live, s0, s1;
        logic [1:0] ne;
        logic [7:0] x;
        int nf;
        if (!rst_n) begin
            m_state = 0; m_frame = 0; m_line = 0; m_pix = 0;
            m_err = 2'b00; m_trig = 1'b0; m_csum = 8'h00;
            frame_px.delete();
            p1_vs = 0; p2_vs = 0; p1_hr = 0; p2_hr = 0; p1_px = 8'h00;
            return;
        end
        vr   = p1_vs && !p2_vs;
        hrr  = p1_hr && !p2_hr;
        hf   = !p1_hr && p2_hr;
        live = (m_state != 0);
        s0 = live && hf && (m_pix != H);
        s1 = live && vr && ((m_line + (hf ? 1 : 0)) != V);
        ne = clr ? 2'b00 : m_err;
        if (s0) ne[0] = 1'b1;
        if (s1) ne[1] = 1'b1;
        nf = vr ? (m_frame + 1) % 256 : m_frame;
        m_trig = (vr && nf == int'(trig_frame)) || ((ne & ~m_err) != 2'b00);
        if (p1_hr) frame_px.push_back(p1_px);
        if (vr && live) begin
            x = 8'h00;
            foreach (frame_px[i]) x ^= frame_px[i];
`ifdef VPT_CHECKSUM_EN
            m_csum = x;
`endif
            frame_px.delete();
        end
        if (live) begin
            if (hf) m_pix = 0;
            else if (p1_hr) m_pix = (m_pix < 4095) ? m_pix + 1 : 4095;
            if (vr) m_line = 0;
            else if (hf) m_line = (m_line < 4095) ? m_line + 1 : 4095;
        end
        if (vr) m_state = 1;
        else if (m_state == 1 && hrr) m_state = 2;
        else if (m_state == 2 && hf) m_state = 1;
        m_frame = nf;
        m_err   = ne;
        p2_vs = p1_vs; p1_vs = vsync;
        p2_hr = p1_hr; p1_hr = href;
        p1_px = pix;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("frame_cnt", frame_cnt, m_frame);
        chk("line_cnt", line_cnt, m_line);
        chk("pix_cnt", pix_cnt, m_pix);
        chk("state", state, m_state);
        chk("err", err, m_err);
        chk("trig", trig, m_trig);
        chk("csum", csum, m_csum);
        if (trig === 1'b1) trig_cnt++;
    endtask

    task automatic vsync_pulse();
        vsync = 1'b1; href = 1'b0;
        tick(); tick();
        vsync = 1'b0;
        tick(); tick();
    endtask

    task automatic send_line(input int n, input bit pattern);
        href = 1'b1;
        for (int i = 0; i < n; i++) begin
            pix = pattern ? 8'(1 << (i % 4)) : 8'($urandom);
            tick();
        end
        href = 1'b0;
        pix  = 8'($urandom);
        repeat ($urandom_range(2, 4)) tick();
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0;
        // Reset with random pin activity
        repeat (4) begin
            vsync = 1'($urandom); href = 1'($urandom); pix = 8'($urandom);
            trig_frame = 8'($urandom); clr = 1'($urandom);
            tick();
        end
        chk("rst_frame", frame_cnt, 0);
        chk("rst_state", state, 0);
        chk("rst_err_trig", {err, trig}, 0);
        chk("rst_csum", csum, 0);
        vsync = 1'b0; href = 1'b0; clr = 1'b0; trig_frame = 8'd2;
        rst_n = 1'b1;
        repeat (4) tick();
        chk("idle_state", state, 0);
        chk("idle_frame", frame_cnt, 0);

        // Nominal frames with the 1,2,4,8 pixel pattern
        vsync_pulse();
        chk("first_frame", frame_cnt, 1);
        chk("first_state", state, 1);
        for (int f = 1; f <= 3; f++) begin
            repeat (3) send_line(4, 1'b1);
            chk("nom_lines", line_cnt, 3);
            chk("nom_err", err, 0);
            trig_cnt = 0;
            vsync_pulse();
            chk("nom_frame", frame_cnt, f + 1);
            chk("nom_trig_cnt", trig_cnt, (f == 1) ? 1 : 0);
            chk("nom_line_clr", line_cnt, 0);
`ifdef VPT_CHECKSUM_EN
            chk("nom_csum", csum, 8'h0F);
`else
            chk("nom_csum", csum, 8'h00);
`endif
        end

        // Short line: error appears two clocks after href falls
        trig_frame = 8'd99;
        send_line(4, 1'b0);
        href = 1'b1;
        repeat (3) begin pix = 8'($urandom); tick(); end
        href = 1'b0;
        tick(); tick();
        chk("short_err", err, 2'b01);
        chk("short_trig", trig, 1);
        tick();
        chk("short_trig_once", trig, 0);
        repeat (2) tick();
        send_line(4, 1'b0);
        vsync_pulse();
        chk("short_err_hold", err, 2'b01);
        clr = 1'b1; tick(); clr = 1'b0;
        chk("clr_err", err, 0);

        // Third line ends in the same cycle as the frame start
        send_line(4, 1'b0);
        send_line(4, 1'b0);
        href = 1'b1;
        repeat (4) begin pix = 8'($urandom); tick(); end
        href = 1'b0; vsync = 1'b1;
        tick(); tick();
        chk("coinc_err", err, 0);
        vsync = 1'b0;
        tick(); tick();
        send_line(4, 1'b0);
        send_line(4, 1'b0);
        trig_cnt = 0;
        vsync_pulse();
        chk("two_lines_err", err, 2'b10);
        chk("two_lines_trig", trig_cnt, 1);

        // Frame counter wrap fires the trigger on frame 0
        trig_frame = 8'd0;
        while (m_frame != 255) vsync_pulse();
        chk("pre_wrap", frame_cnt, 255);
        trig_cnt = 0;
        vsync_pulse();
        chk("wrap_frame", frame_cnt, 0);
        chk("wrap_trig", trig_cnt, 1);

        // Randomized well-formed frames
        clr = 1'b1; tick(); clr = 1'b0;
        for (int f = 0; f < 5; f++) begin
            trig_frame = ($urandom_range(0, 1) == 0) ? 8'(m_frame + 1) : 8'($urandom);
            vsync_pulse();
            repeat ($urandom_range(2, 4)) send_line($urandom_range(3, 5), 1'b0);
            clr = ($urandom_range(0, 2) == 0);
            tick();
            clr = 1'b0;
        end

        // Free-running random pins, including a mid-frame reset
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) vsync = ~vsync;
            if ($urandom_range(0, 5) == 0) href = ~href;
            pix = 8'($urandom);
            clr = ($urandom_range(0, 29) == 0);
            trig_frame = ($urandom_range(0, 3) == 0) ? 8'(m_frame + 1) : 8'($urandom);
            if (i == 200) begin
                rst_n = 1'b0;
                tick();
                chk("midrst_state", state, 0);
                chk("midrst_counts", {frame_cnt, line_cnt, pix_cnt}, 0);
                rst_n = 1'b1;
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_probe_tap.md
# video_probe_tap

Capture-side debug stage that sits directly upstream of the ChipWatcher probe wrapper in the camera/HDMI path. It samples the camera video timing (vsync, href, 8-bit pixel), tracks frame, line and pixel counters, checks line and frame geometry against expected sizes, and produces a registered probe bundle with a single-cycle trigger pulse. Every output is a flop and connects straight onto a probe input.

## Interface
Parameters:
- H_ACT, 640: expected active pixels per line.
- V_ACT, 480: expected active lines per frame.
- PIX_W, 12: width of the pixel counter.
- LINE_W, 12: width of the line counter.

Ports:
- clk  in  1  system clock; all logic is on this edge.
- rst_n  in  1  reset, asynchronous active-low; one clock domain only.
- vsync_i  in  1  frame sync, active-high; a rising edge marks a frame start.
- href_i  in  1  line valid, active-high.
- pix_i  in  8  pixel data, qualified by href_i.
- trig_frame_i  in  8  frame number that fires the trigger.
- clr_i  in  1  single-cycle clear of the sticky error flags.
- frame_cnt_o  out  8  frame counter, wraps 255→0.
- line_cnt_o  out  LINE_W  completed lines in the current frame.
- pix_cnt_o  out  PIX_W  pixels in the current line.
- state_o  out  2  FSM state encoding.
- err_o  out  2  sticky errors; bit0 = line-length mismatch, bit1 = line-count mismatch.
- trig_o  out  1  one-cycle trigger pulse.
- csum_o  out  8  per-frame XOR checksum; 0 when the feature is compiled out.

## Operation
- Input stage: vsync_i, href_i and pix_i are registered into r1, then r1 into r2.
  - vs_rise = vs_r1 & ~vs_r2.
  - hr_rise = hr_r1 & ~hr_r2.
  - hr_fall = ~hr_r1 & hr_r2.
- FSM states:
  - IDLE (0): waits for the first vs_rise, then goes to VBLANK. No geometry check runs on this transition.
  - VBLANK (1): hr_rise goes to ACTIVE.
  - ACTIVE (2): hr_fall goes to VBLANK.
  - From VBLANK or ACTIVE, vs_rise goes to VBLANK and ends the frame.
  - Encoding 3 is unused and decodes to IDLE.
- pix_cnt: increments every cycle hr_r1=1 while the state is not IDLE. It saturates at 2^PIX_W-1. It clears the cycle after hr_fall.
- Line end (hr_fall, state not IDLE):
  - line_cnt += 1, saturating.
  - If pix_cnt != H_ACT, set err_o[0].
- Frame end (vs_rise, state not IDLE):
  - If the effective line count != V_ACT, set err_o[1]. If hr_fall happens in the same cycle, the effective count includes that line (count+1).
  - line_cnt clears to 0.
  - frame_cnt += 1.
- Any vs_rise, including the first one out of IDLE, increments frame_cnt.
- Trigger: trig_o=1 for exactly one cycle when either:
  - vs_rise occurs and the new frame_cnt equals trig_frame_i, or
  - an err_o bit goes 0→1.
  If both happen in one cycle, there is still only one pulse.
- Error flags: clr_i clears err_o. If clr_i and a new error occur in the same cycle, the set wins, so no event is lost.
- Reset values: every output is 0, and state_o = IDLE. Asserting reset mid-frame discards all counts. The next frame start returns the block to IDLE behaviour, with no check on the first frame.

## Timing
- Latency from an input edge at the pins to the updated counter/err/trig outputs is 2 clocks: one input register, then one update register.
- state_o changes on the same clock as the counters.
- trig_o is high for one cycle, never two in a row from a single event.
- No handshake: the inputs are free-running and the outputs are plain sampled registers.

## Configuration
- VPT_CHECKSUM_EN defined:
  - An 8-bit accumulator XORs pix_r1 on every cycle where hr_r1=1.
  - On vs_rise (state not IDLE), csum_o latches the accumulator value including the current cycle's contribution, and the accumulator clears.
- VPT_CHECKSUM_EN undefined: csum_o is tied to 0 and the accumulator logic is not synthesized.

## Test plan
- Reset: with rst_n low, drive random inputs → all outputs 0, state_o=0. Release rst_n → all stay 0 until the first vsync.
- Nominal, with H_ACT=4, V_ACT=3: vsync, then 3 lines of 4 pixels, then vsync, repeated for 3 frames → err_o=0, frame_cnt_o steps 1,2,3, line_cnt_o reaches 3 before each clear.
- Short line: one 3-pixel line in frame 2 → err_o[0]=1 two clocks after href falls, trig_o pulses once. Pulse clr_i → err_o=0.
- Frame-count mismatch, with hr_fall coincident with vs_rise on the third line → no err_o[1]. With only 2 lines → err_o[1]=1.
- Trigger match: trig_frame_i=2 → a single trig_o pulse on the vs_rise that takes frame_cnt_o to 2. Wrap check: frame 255→0 with trig_frame_i=0 → pulse on the wrap.
- With VPT_CHECKSUM_EN, pixels 0x01,0x02,0x04,0x08 on each of 3 lines → csum_o=0x0F at the next vsync. Without the macro → csum_o stays 0.
